// File: rtl/hazard_unit_if.sv
// D-stage hazard query bundle: decoded D-stage operand/result fields in, stall/forward controls out.
interface hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_tuse_rs;
  logic [TW-1:0]     d_tuse_rt;
  logic [REG_AW-1:0] d_dst;
  logic              d_we;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              stall;
  logic [1:0]        fwd_d_rs;
  logic [1:0]        fwd_d_rt;
  logic [1:0]        fwd_e_rs;
  logic [1:0]        fwd_e_rt;
  logic              fwd_m_rt;
  logic              md_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt,
           md_busy, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt,
           md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Tuse/Tnew hazard unit for a 5-stage pipeline with a multi-cycle mult/div unit.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter; otherwise stall_cnt is tied to 0.
module hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] dst;
    logic [TW-1:0]     tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } slot_t;

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  slot_t            e_reg, m_reg, w_reg;
  slot_t            e_next, m_next, w_next;
  logic             e_md_start_reg, e_md_div_reg;
  logic             e_md_start_next, e_md_div_next;
  logic [MD_W-1:0]  md_cnt_reg;
  logic             md_busy;
  logic             md_stall;
  logic             stall;

  logic [1:0][REG_AW-1:0] d_src;
  logic [1:0][REG_AW-1:0] e_src;
  logic [1:0][TW-1:0]     d_tuse;
  logic [1:0][1:0]        fwd_d;
  logic [1:0][1:0]        fwd_e;
  logic [1:0]             op_haz;

  assign d_src  = {hz.d_rt, hz.d_rs};
  assign e_src  = {e_reg.rt, e_reg.rs};
  assign d_tuse = {hz.d_tuse_rt, hz.d_tuse_rs};

  // Index 0 is rs, index 1 is rt; a zero source never hits because slot we is cleared for $0.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
    logic e_hit, m_hit, w_hit, me_hit, we_hit;
    assign e_hit  = (d_src[gi] != '0) && e_reg.we && (e_reg.dst == d_src[gi]);
    assign m_hit  = (d_src[gi] != '0) && m_reg.we && (m_reg.dst == d_src[gi]);
    assign w_hit  = (d_src[gi] != '0) && w_reg.we && (w_reg.dst == d_src[gi]);
    assign me_hit = (e_src[gi] != '0) && m_reg.we && (m_reg.dst == e_src[gi]);
    assign we_hit = (e_src[gi] != '0) && w_reg.we && (w_reg.dst == e_src[gi]);

    assign op_haz[gi] = (e_hit && (e_reg.tnew > d_tuse[gi])) ||
                        (m_hit && (m_reg.tnew > d_tuse[gi]));

    // Only the youngest producer may forward; if it is not ready, fall back to the regfile value.
    assign fwd_d[gi] = e_hit ? ((e_reg.tnew == '0) ? 2'b01 : 2'b00) :
                       m_hit ? ((m_reg.tnew == '0) ? 2'b10 : 2'b00) :
                       w_hit ? ((w_reg.tnew == '0) ? 2'b11 : 2'b00) : 2'b00;

    assign fwd_e[gi] = me_hit ? ((m_reg.tnew == '0) ? 2'b10 : 2'b00) :
                       (we_hit && (w_reg.tnew == '0)) ? 2'b11 : 2'b00;
  end

  assign md_busy  = (md_cnt_reg != '0);
  // A mult/div sitting in E has not loaded the counter yet, so it blocks HI/LO users too.
  assign md_stall = (hz.d_md_start || hz.d_md_use) && (md_busy || e_md_start_reg);
  assign stall    = (|op_haz) || md_stall;

  always_comb begin
    e_next          = '0;
    e_md_start_next = 1'b0;
    e_md_div_next   = 1'b0;
    if (!stall) begin
      e_next.we       = hz.d_we && (hz.d_dst != '0);
      e_next.dst      = hz.d_dst;
      e_next.tnew     = hz.d_tnew;
      e_next.rs       = hz.d_rs;
      e_next.rt       = hz.d_rt;
      e_md_start_next = hz.d_md_start;
      e_md_div_next   = hz.d_md_div;
    end
    m_next      = e_reg;
    m_next.tnew = dec_sat(e_reg.tnew);
    w_next      = m_reg;
    w_next.tnew = dec_sat(m_reg.tnew);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_reg          <= '0;
      m_reg          <= '0;
      w_reg          <= '0;
      e_md_start_reg <= 1'b0;
      e_md_div_reg   <= 1'b0;
      md_cnt_reg     <= '0;
    end else begin
      e_reg          <= e_next;
      m_reg          <= m_next;
      w_reg          <= w_next;
      e_md_start_reg <= e_md_start_next;
      e_md_div_reg   <= e_md_div_next;
      if (e_md_start_reg) begin
        md_cnt_reg <= e_md_div_reg ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
      end else if (md_busy) begin
        md_cnt_reg <= md_cnt_reg - 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
`endif

  // W keeps its source fields only for slot symmetry; nothing downstream reads them.
  logic w_unused;
  assign w_unused = ^{w_reg.rs, w_reg.rt};

  assign hz.stall    = stall;
  assign hz.fwd_d_rs = fwd_d[0];
  assign hz.fwd_d_rt = fwd_d[1];
  assign hz.fwd_e_rs = fwd_e[0];
  assign hz.fwd_e_rt = fwd_e[1];
  assign hz.fwd_m_rt = w_reg.we && (w_reg.dst == m_reg.rt);
  assign hz.md_busy  = md_busy;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stalls, forwarding, mult/div interlock, reset and stall counter.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(5), .TW(2), .CNT_W(32)) hz ();

  hazard_unit #(
    .REG_AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hz)
  );

  task automatic drive(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] dst, input logic we, input logic [1:0] tnew,
                       input logic md_start, input logic md_div, input logic md_use);
    hz.d_rs = rs;  hz.d_tuse_rs = tu_rs;
    hz.d_rt = rt;  hz.d_tuse_rt = tu_rt;
    hz.d_dst = dst; hz.d_we = we; hz.d_tnew = tnew;
    hz.d_md_start = md_start; hz.d_md_div = md_div; hz.d_md_use = md_use;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", hz.stall); end
    checks++;
    if ({hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt} !== 9'd0) begin
      failures++; $display("FAIL reset_fwd: got %b want 000000000",
                           {hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt});
    end
    checks++;
    if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL reset_md_busy: got %b want 0", hz.md_busy); end
    checks++;
    if (hz.stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d want 0", hz.stall_cnt); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    $display("test_reset: done");
  endtask

  // lw $8 (tnew 2) then addu $10,$8,$9 (tuse 1)
  task automatic test_lw_use();
    tick(); drive(29, 1, 0, 0, 8, 1, 2, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL lw_issue_stall: got %b want 0", hz.stall); end
    tick(); drive(8, 1, 9, 1, 10, 1, 1, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b1) begin failures++; $display("FAIL lw_use_stall: got %b want 1", hz.stall); end
    checks++;
    if (hz.fwd_d_rs !== 2'b00) begin failures++; $display("FAIL lw_use_fwd_d_e: got %b want 00", hz.fwd_d_rs); end
    tick(); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL lw_use_release: got %b want 0", hz.stall); end
    checks++;
    if (hz.fwd_d_rs !== 2'b00) begin failures++; $display("FAIL lw_use_fwd_d_m: got %b want 00", hz.fwd_d_rs); end
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.fwd_e_rs !== 2'b11) begin failures++; $display("FAIL lw_use_fwd_e_rs: got %b want 11", hz.fwd_e_rs); end
    checks++;
    if (hz.fwd_e_rt !== 2'b00) begin failures++; $display("FAIL lw_use_fwd_e_rt: got %b want 00", hz.fwd_e_rt); end
    $display("test_lw_use: done");
  endtask

  // ori $9 (tnew 1) then beq $9,$0 (tuse 0)
  task automatic test_ori_beq();
    tick(); drive(0, 1, 0, 0, 9, 1, 1, 0, 0, 0); #1;
    tick(); drive(9, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b1) begin failures++; $display("FAIL ori_beq_stall: got %b want 1", hz.stall); end
    tick(); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL ori_beq_release: got %b want 0", hz.stall); end
    checks++;
    if (hz.fwd_d_rs !== 2'b10) begin failures++; $display("FAIL ori_beq_fwd_d: got %b want 10", hz.fwd_d_rs); end
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test_ori_beq: done");
  endtask

  // jal ($31, tnew 0), jr $31, then beq $31,$31 as the producer walks M and W
  task automatic test_jal_jr();
    tick(); drive(0, 0, 0, 0, 31, 1, 0, 0, 0, 0); #1;
    tick(); drive(31, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL jal_jr_stall: got %b want 0", hz.stall); end
    checks++;
    if (hz.fwd_d_rs !== 2'b01) begin failures++; $display("FAIL jal_jr_fwd_d: got %b want 01", hz.fwd_d_rs); end
    tick(); drive(31, 0, 31, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if ({hz.fwd_d_rs, hz.fwd_d_rt} !== 4'b1010) begin
      failures++; $display("FAIL jal_fwd_d_m: got %b want 1010", {hz.fwd_d_rs, hz.fwd_d_rt});
    end
    checks++;
    if (hz.fwd_e_rs !== 2'b10) begin failures++; $display("FAIL jal_fwd_e_m: got %b want 10", hz.fwd_e_rs); end
    tick(); #1;
    checks++;
    if (hz.fwd_d_rs !== 2'b11) begin failures++; $display("FAIL jal_fwd_d_w: got %b want 11", hz.fwd_d_rs); end
    checks++;
    if ({hz.fwd_e_rs, hz.fwd_e_rt} !== 4'b1111) begin
      failures++; $display("FAIL jal_fwd_e_w: got %b want 1111", {hz.fwd_e_rs, hz.fwd_e_rt});
    end
    $display("test_jal_jr: done");
  endtask

  // lw $8 then sw $8 (tuse 2): no stall, store data forwarded from W into M
  task automatic test_store_fwd();
    tick(); drive(29, 1, 0, 0, 8, 1, 2, 0, 0, 0); #1;
    tick(); drive(29, 1, 8, 2, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL store_stall: got %b want 0", hz.stall); end
    checks++;
    if (hz.fwd_d_rt !== 2'b00) begin failures++; $display("FAIL store_fwd_d_rt: got %b want 00", hz.fwd_d_rt); end
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.fwd_e_rt !== 2'b00) begin failures++; $display("FAIL store_fwd_e_rt: got %b want 00", hz.fwd_e_rt); end
    tick(); #1;
    checks++;
    if (hz.fwd_m_rt !== 1'b1) begin failures++; $display("FAIL store_fwd_m_rt: got %b want 1", hz.fwd_m_rt); end
    tick(); #1;
    checks++;
    if (hz.fwd_m_rt !== 1'b0) begin failures++; $display("FAIL store_fwd_m_rt_clear: got %b want 0", hz.fwd_m_rt); end
    $display("test_store_fwd: done");
  endtask

  // addu $0 then beq $0,$0: register zero never interlocks
  task automatic test_r0();
    tick(); drive(0, 1, 0, 1, 0, 1, 1, 0, 0, 0); #1;
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL r0_stall: got %b want 0", hz.stall); end
    checks++;
    if ({hz.fwd_d_rs, hz.fwd_d_rt} !== 4'b0000) begin
      failures++; $display("FAIL r0_fwd_d: got %b want 0000", {hz.fwd_d_rs, hz.fwd_d_rt});
    end
    tick(); #1;
    checks++;
    if ({hz.fwd_e_rs, hz.fwd_e_rt} !== 4'b0000) begin
      failures++; $display("FAIL r0_fwd_e: got %b want 0000", {hz.fwd_e_rs, hz.fwd_e_rt});
    end
    $display("test_r0: done");
  endtask

  // div then mflo: 11 stall cycles, md_busy high for 10 of them
  task automatic test_div_mflo();
    int stall_cycles = 0;
    int busy_cycles = 0;
    tick(); drive(4, 1, 5, 1, 0, 0, 0, 1, 1, 0); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL div_issue_stall: got %b want 0", hz.stall); end
    tick(); drive(0, 0, 0, 0, 2, 1, 1, 0, 0, 1); #1;
    for (int i = 0; i < 40 && hz.stall; i++) begin
      stall_cycles++;
      if (hz.md_busy) busy_cycles++;
      tick(); #1;
    end
    checks++;
    if (stall_cycles != 11) begin failures++; $display("FAIL div_stall_cycles: got %0d want 11", stall_cycles); end
    checks++;
    if (busy_cycles != 10) begin failures++; $display("FAIL div_busy_cycles: got %0d want 10", busy_cycles); end
    checks++;
    if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL div_busy_end: got %b want 0", hz.md_busy); end
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test_div_mflo: done");
  endtask

  // mult then mult: second one waits 1 + MULT_CYC cycles, then starts the unit itself
  task automatic test_back_to_back();
    int stall_cycles = 0;
    tick(); drive(4, 1, 5, 1, 0, 0, 0, 1, 0, 0); #1;
    tick(); #1;
    for (int i = 0; i < 40 && hz.stall; i++) begin
      stall_cycles++;
      tick(); #1;
    end
    checks++;
    if (stall_cycles != 6) begin failures++; $display("FAIL mult_b2b_stall_cycles: got %0d want 6", stall_cycles); end
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    tick(); #1;
    checks++;
    if (hz.md_busy !== 1'b1) begin failures++; $display("FAIL mult_b2b_busy: got %b want 1", hz.md_busy); end
    $display("test_back_to_back: done");
  endtask

  // asynchronous reset while the multiplier is busy and mfhi is waiting
  task automatic test_reset_mid_md();
    drive(0, 0, 0, 0, 3, 1, 1, 0, 0, 1); #1;
    checks++;
    if (hz.stall !== 1'b1) begin failures++; $display("FAIL mid_md_stall: got %b want 1", hz.stall); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL mid_md_busy: got %b want 0", hz.md_busy); end
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL mid_md_stall_clear: got %b want 0", hz.stall); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); #1;
    checks++;
    if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL mid_md_busy_after: got %b want 0", hz.md_busy); end
    $display("test_reset_mid_md: done");
  endtask

  // exactly three stall cycles (lw->beq twice, ori->beq once), then reset
  task automatic test_perf_cnt();
    logic [31:0] exp_cnt;
`ifdef HAZARD_PERF_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    tick(); drive(29, 1, 0, 0, 8, 1, 2, 0, 0, 0); #1;
    tick(); drive(8, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if (hz.stall !== 1'b1) begin failures++; $display("FAIL perf_lw_stall_e: got %b want 1", hz.stall); end
    tick(); #1;
    checks++;
    if (hz.stall !== 1'b1) begin failures++; $display("FAIL perf_lw_stall_m: got %b want 1", hz.stall); end
    tick(); #1;
    checks++;
    if (hz.stall !== 1'b0) begin failures++; $display("FAIL perf_lw_release: got %b want 0", hz.stall); end
    checks++;
    if (hz.fwd_d_rs !== 2'b11) begin failures++; $display("FAIL perf_lw_fwd_d_w: got %b want 11", hz.fwd_d_rs); end
    tick(); drive(0, 1, 0, 0, 9, 1, 1, 0, 0, 0); #1;
    tick(); drive(9, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    tick(); #1;
    checks++;
    if (hz.stall_cnt !== exp_cnt) begin failures++; $display("FAIL perf_stall_cnt: got %0d want %0d", hz.stall_cnt, exp_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (hz.stall_cnt !== 32'd0) begin failures++; $display("FAIL perf_stall_cnt_reset: got %0d want 0", hz.stall_cnt); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    $display("test_perf_cnt: done");
  endtask

  initial begin
    test_reset();
    test_lw_use();
    test_ori_beq();
    test_jal_jr();
    test_store_fwd();
    test_r0();
    test_div_mflo();
    test_back_to_back();
    test_reset_mid_md();
    test_perf_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
